// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter for the integer register file write port.
// Merges ALU results with a FIFO-buffered long-latency stream, tracks pending rd.
module regfile_wb_ctrl #(
  parameter int LU_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [4:0]  w_addr,
  output logic [31:0] w_data,
  output logic        WEN
);

  localparam int AW = $clog2(LU_DEPTH);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(LU_DEPTH);
  localparam logic [SW-1:0] SMAX     = SW'(STARVE_MAX);

  logic [4:0]    rd_mem_q  [LU_DEPTH];
  logic [31:0]   dat_mem_q [LU_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;
  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;
  logic [31:0]   sb_q;
  logic [31:0]   sb_d;
  logic          wen_q;
  logic          src_lu_q;
  logic [4:0]    waddr_q;
  logic [31:0]   wdata_q;

  logic          empty;
  logic          full;
  logic          push;
  logic          lu_grant;
  logic          alu_grant;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == FULL_CNT);
  assign lu_ready  = !full;
  assign push      = lu_valid & !full;
  assign lu_grant  = !empty & (!alu_valid | (starve_q == SMAX));
  assign alu_stall = alu_valid & lu_grant;
  assign alu_grant = alu_valid & !alu_stall;
  assign head_rd   = rd_mem_q[rptr_q];
  assign head_data = dat_mem_q[rptr_q];

  assign issue_ready = !sb_q[issue_rd];
  assign rs1_busy    = sb_q[rs1_addr];
  assign rs2_busy    = sb_q[rs2_addr];

  assign w_addr = waddr_q;
  assign w_data = wdata_q;
  assign WEN    = wen_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, lu_grant})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (empty || lu_grant)
      starve_d = '0;
    else if (alu_grant && starve_q != SMAX)
      starve_d = starve_q + 1'b1;
  end

  // Busy holds until the LU write has actually landed in the regfile.
  always_comb begin
    sb_d = sb_q;
    if (wen_q && src_lu_q)
      sb_d[waddr_q] = 1'b0;
    if (issue_valid && issue_ready && issue_rd != 5'd0)
      sb_d[issue_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      sb_q     <= '0;
      wen_q    <= 1'b0;
      src_lu_q <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      for (int i = 0; i < LU_DEPTH; i++) begin
        rd_mem_q[i]  <= '0;
        dat_mem_q[i] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      sb_q     <= sb_d;
      if (push) begin
        rd_mem_q[wptr_q]  <= lu_rd;
        dat_mem_q[wptr_q] <= lu_data;
        wptr_q            <= wptr_q + 1'b1;
      end
      if (lu_grant)
        rptr_q <= rptr_q + 1'b1;
      unique case (1'b1)
        lu_grant: begin
          waddr_q  <= head_rd;
          wdata_q  <= head_data;
          wen_q    <= (head_rd != 5'd0);
          src_lu_q <= 1'b1;
        end
        alu_grant: begin
          waddr_q  <= alu_rd;
          wdata_q  <= alu_data;
          wen_q    <= (alu_rd != 5'd0);
          src_lu_q <= 1'b0;
        end
        default: begin
          wen_q    <= 1'b0;
          src_lu_q <= 1'b0;
        end
      endcase
    end
  end

  // Issue logic must never let the ALU target a pending long-latency rd.
  a_alu_raw: assert property (@(posedge clk) disable iff (!rst_n)
    !(alu_grant && alu_rd != 5'd0 && sb_q[alu_rd]));

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile_wb_ctrl;

  localparam int DEPTH = 2;
  localparam int SMAX  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        WEN;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_wb_ctrl #(.LU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .alu_stall(alu_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd),
    .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .w_addr(w_addr), .w_data(w_data), .WEN(WEN)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  logic        m_wen;
  logic        m_src;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic [31:0] m_sb;

  // Reference model: FIFO as a queue, outputs derived from arbitration rules.
  always @(negedge clk) begin
    bit   emp;
    bit   rdy;
    bit   lg;
    bit   ag;
    bit   ir;
    ent_t h;
    if (!rst_n) begin
      mq.delete();
      m_starve = 0;
      m_wen = 1'b0;
      m_src = 1'b0;
      m_wa = '0;
      m_wd = '0;
      m_sb = '0;
    end
    emp = (mq.size() == 0);
    rdy = (mq.size() < DEPTH);
    lg  = !emp && (!alu_valid || m_starve == SMAX);
    ag  = alu_valid && !lg;
    ir  = (issue_rd == 5'd0) || !m_sb[issue_rd];
    chk("m_wen", 32'(WEN), 32'(m_wen));
    chk("m_waddr", 32'(w_addr), 32'(m_wa));
    chk("m_wdata", w_data, m_wd);
    chk("m_lu_ready", 32'(lu_ready), 32'(rdy));
    chk("m_alu_stall", 32'(alu_stall), 32'(alu_valid && lg));
    chk("m_issue_ready", 32'(issue_ready), 32'(ir));
    chk("m_rs1_busy", 32'(rs1_busy), 32'(m_sb[rs1_addr]));
    chk("m_rs2_busy", 32'(rs2_busy), 32'(m_sb[rs2_addr]));
    if (rst_n) begin
      if (m_wen && m_src) m_sb[m_wa] = 1'b0;
      if (issue_valid && ir && issue_rd != 5'd0) m_sb[issue_rd] = 1'b1;
      if (lg) begin
        h = mq.pop_front();
        m_wa = h.rd;
        m_wd = h.d;
        m_wen = (h.rd != 5'd0);
        m_src = 1'b1;
      end else if (ag) begin
        m_wa = alu_rd;
        m_wd = alu_data;
        m_wen = (alu_rd != 5'd0);
        m_src = 1'b0;
      end else begin
        m_wen = 1'b0;
        m_src = 1'b0;
      end
      if (emp || lg) m_starve = 0;
      else if (ag && m_starve < SMAX) m_starve++;
      if (lu_valid && rdy) begin
        h.rd = lu_rd;
        h.d  = lu_data;
        mq.push_back(h);
      end
    end
  end

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd = '0;
    alu_data = '0;
    lu_valid = 1'b0;
    lu_rd = '0;
    lu_data = '0;
    issue_valid = 1'b0;
    issue_rd = '0;
    rs1_addr = '0;
    rs2_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int ai;
    int li;
    int stalls;
    int wcnt;
    bit st;
    bit acc_a;
    bit acc_l;

    idle();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    mid();
    chk("rst_wen", 32'(WEN), 0);
    chk("rst_waddr", 32'(w_addr), 0);
    chk("rst_wdata", w_data, 0);
    chk("rst_lu_ready", 32'(lu_ready), 1);
    chk("rst_alu_stall", 32'(alu_stall), 0);
    chk("rst_issue_ready", 32'(issue_ready), 1);
    chk("rst_rs1_busy", 32'(rs1_busy), 0);
    step();

    // single LU result, two-cycle latency to WEN
    lu_valid = 1'b1;
    lu_rd = 5'd5;
    lu_data = 32'hDEAD_BEEF;
    mid();
    chk("t1_wen_c0", 32'(WEN), 0);
    step();
    idle();
    mid();
    chk("t1_wen_c1", 32'(WEN), 0);
    step();
    mid();
    chk("t1_wen_c2", 32'(WEN), 1);
    chk("t1_waddr", 32'(w_addr), 5);
    chk("t1_wdata", w_data, 32'hDEAD_BEEF);
    step();
    mid();
    chk("t1_wen_c3", 32'(WEN), 0);
    step();

    // scoreboard set on issue, cleared when LU data lands
    issue_valid = 1'b1;
    issue_rd = 5'd7;
    rs1_addr = 5'd7;
    mid();
    chk("t2_issue_rdy0", 32'(issue_ready), 1);
    chk("t2_busy0", 32'(rs1_busy), 0);
    step();
    issue_valid = 1'b0;
    mid();
    chk("t2_busy1", 32'(rs1_busy), 1);
    chk("t2_issue_rdy1", 32'(issue_ready), 0);
    step();
    lu_valid = 1'b1;
    lu_rd = 5'd7;
    lu_data = 32'h77;
    mid();
    step();
    lu_valid = 1'b0;
    mid();
    chk("t2_busy_head", 32'(rs1_busy), 1);
    step();
    mid();
    chk("t2_wen", 32'(WEN), 1);
    chk("t2_waddr", 32'(w_addr), 7);
    chk("t2_busy_wen", 32'(rs1_busy), 1);
    step();
    mid();
    chk("t2_busy_clr", 32'(rs1_busy), 0);
    chk("t2_issue_rdy2", 32'(issue_ready), 1);
    step();
    idle();
    repeat (2) step();

    // starvation bound: 4 ALU wins, then one stall for the LU entry
    ai = 0;
    stalls = 0;
    lu_valid = 1'b1;
    lu_rd = 5'd20;
    lu_data = 32'hA0;
    alu_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      alu_rd = 5'(1 + ai);
      alu_data = 32'h100 + 32'(ai);
      mid();
      if (i == 5) chk("t3_stall", 32'(alu_stall), 1);
      if (i == 6) begin
        chk("t3_lu_wen", 32'(WEN), 1);
        chk("t3_lu_waddr", 32'(w_addr), 20);
        chk("t3_lu_wdata", w_data, 32'hA0);
      end
      if (i == 7) begin
        chk("t3_held_waddr", 32'(w_addr), 6);
        chk("t3_held_wdata", w_data, 32'h105);
      end
      st = alu_stall;
      if (st) stalls++;
      step();
      lu_valid = 1'b0;
      if (!st) ai++;
    end
    chk("t3_stall_cnt", 32'(stalls), 1);
    idle();
    repeat (3) step();

    // FIFO fill, backpressure, wrap over 5 entries
    ai = 0;
    li = 0;
    wcnt = 0;
    for (int i = 0; i < 30; i++) begin
      alu_valid = (ai < 12);
      alu_rd = 5'(10 + ai);
      alu_data = 32'hA000 + 32'(ai);
      lu_valid = (li < 5);
      lu_rd = 5'(24 + li);
      lu_data = 32'hB000 + 32'(li);
      mid();
      if (i == 2) chk("t4_full", 32'(lu_ready), 0);
      if (i == 5) begin
        chk("t4_full_pop", 32'(lu_ready), 0);
        chk("t4_stall", 32'(alu_stall), 1);
      end
      if (i == 6) chk("t4_ready_again", 32'(lu_ready), 1);
      if (WEN) wcnt++;
      acc_a = alu_valid && !alu_stall;
      acc_l = lu_valid && lu_ready;
      step();
      if (acc_a) ai++;
      if (acc_l) li++;
    end
    chk("t4_lu_accepted", 32'(li), 5);
    chk("t4_write_cnt", 32'(wcnt), 17);
    idle();
    repeat (2) step();

    // rd 0 results are consumed without a write
    alu_valid = 1'b1;
    alu_rd = 5'd0;
    alu_data = 32'h55;
    lu_valid = 1'b1;
    lu_rd = 5'd0;
    lu_data = 32'h1234;
    mid();
    step();
    idle();
    mid();
    chk("t5_alu_wen", 32'(WEN), 0);
    chk("t5_alu_wdata", w_data, 32'h55);
    step();
    mid();
    chk("t5_lu_wen", 32'(WEN), 0);
    chk("t5_lu_wdata", w_data, 32'h1234);
    chk("t5_lu_waddr", 32'(w_addr), 0);
    step();
    mid();
    chk("t5_drained", 32'(lu_ready), 1);
    chk("t5_busy", 32'(rs1_busy), 0);
    step();

    // async reset mid-stream discards FIFO and pending bits
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1'b1;
      issue_rd = 5'(11 + k);
      step();
    end
    idle();
    alu_valid = 1'b1;
    alu_rd = 5'd1;
    alu_data = 32'h61;
    lu_valid = 1'b1;
    lu_rd = 5'd11;
    lu_data = 32'hC1;
    step();
    alu_rd = 5'd2;
    alu_data = 32'h62;
    lu_rd = 5'd12;
    lu_data = 32'hC2;
    step();
    idle();
    rs1_addr = 5'd11;
    rs2_addr = 5'd12;
    mid();
    chk("t6_pre_full", 32'(lu_ready), 0);
    chk("t6_pre_busy1", 32'(rs1_busy), 1);
    chk("t6_pre_busy2", 32'(rs2_busy), 1);
    chk("t6_pre_wen", 32'(WEN), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_wen", 32'(WEN), 0);
    chk("t6_rst_busy1", 32'(rs1_busy), 0);
    chk("t6_rst_busy2", 32'(rs2_busy), 0);
    chk("t6_rst_ready", 32'(lu_ready), 1);
    chk("t6_rst_waddr", 32'(w_addr), 0);
    step();
    step();
    rst_n = 1'b1;
    wcnt = 0;
    for (int i = 0; i < 8; i++) begin
      mid();
      if (WEN) wcnt++;
      step();
    end
    chk("t6_no_stale", 32'(wcnt), 0);
    rs1_addr = 5'd13;
    mid();
    chk("t6_busy13", 32'(rs1_busy), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
